// File: rtl/extend_byte.sv
// extend_byte: registered byte-to-word extender for the load/immediate path.
//
// Captures an 8-bit source on a clock edge when in_valid_i is high and
// presents it one cycle later, sign- or zero-extended to OUT_W bits, with
// a matching valid flag. The result holds when no capture occurs.
//
// Optional build macro: EXTEND_BYTE_HALF_EN
//   Adds a 16-bit halfword source selectable per capture via size_sel_i.
//
// Ports:
//   clk_i            rising-edge clock
//   reset_i          synchronous, active-high reset
//   byte_i           source byte (IN_W bits)
//   SIG_ExtByte_i    1 = sign-extend, 0 = zero-extend
//   in_valid_i       sample the source and mode this cycle
//   half_i           source halfword       (EXTEND_BYTE_HALF_EN only)
//   size_sel_i       0 = byte, 1 = half    (EXTEND_BYTE_HALF_EN only)
//   extendedValue_o  registered extended result (OUT_W bits)
//   out_valid_o      result was captured on the previous edge
//
// The keyword "byte" cannot be used as a port name, so all ports carry
// _i/_o suffixes.

module extend_byte #(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned IN_W  = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IN_W-1:0]  byte_i,
  input  logic             SIG_ExtByte_i,
  input  logic             in_valid_i,
`ifdef EXTEND_BYTE_HALF_EN
  input  logic [15:0]      half_i,
  input  logic             size_sel_i,
`endif
  output logic [OUT_W-1:0] extendedValue_o,
  output logic             out_valid_o
);

  logic [OUT_W-1:0] value_q, value_d;
  logic             valid_q, valid_d;

  // Sources and mode are read only under in_valid_i, so unknowns on them
  // while idle select the hold path and never reach the registers.
  always_comb begin
    value_d = value_q;
    valid_d = 1'b0;
    if (in_valid_i) begin
      valid_d = 1'b1;
`ifdef EXTEND_BYTE_HALF_EN
      if (size_sel_i) begin
        value_d = {{(OUT_W-16){SIG_ExtByte_i & half_i[15]}}, half_i};
      end else begin
        value_d = {{(OUT_W-IN_W){SIG_ExtByte_i & byte_i[IN_W-1]}}, byte_i};
      end
`else
      value_d = {{(OUT_W-IN_W){SIG_ExtByte_i & byte_i[IN_W-1]}}, byte_i};
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign extendedValue_o = value_q;
  assign out_valid_o     = valid_q;

endmodule

// File: tb/tb_extend_byte.sv
// Testbench for extend_byte: directed vectors with literal expectations plus
// a bench-side arithmetic model compared on every cycle after first reset.
module tb_extend_byte;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  byte_i;
  logic        SIG_ExtByte_i;
  logic        in_valid_i;
  logic [15:0] half_i;
  logic        size_sel_i;
  logic [31:0] extendedValue_o;
  logic        out_valid_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  extend_byte #(.OUT_W(32), .IN_W(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .byte_i         (byte_i),
    .SIG_ExtByte_i  (SIG_ExtByte_i),
    .in_valid_i     (in_valid_i),
`ifdef EXTEND_BYTE_HALF_EN
    .half_i         (half_i),
    .size_sel_i     (size_sel_i),
`endif
    .extendedValue_o(extendedValue_o),
    .out_valid_o    (out_valid_o)
  );

  // Model: treat the source as a number; in signed mode values in the upper
  // half of the range represent value - 2^width.
  function automatic logic [31:0] extend(input logic [15:0] v, input logic is_half,
                                         input logic sgn);
    int x;
    if (is_half) begin
      x = int'(v);
      if (sgn && x >= 32768) x = x - 65536;
    end else begin
      x = int'(v[7:0]);
      if (sgn && x >= 128) x = x - 256;
    end
    return 32'(x);
  endfunction

  logic [31:0] m_val;
  logic        m_vld;
  logic        armed = 1'b0;

  always @(posedge clk) begin
    if (reset_i === 1'b1) begin
      m_val <= '0;
      m_vld <= 1'b0;
      armed <= 1'b1;
    end else if (in_valid_i === 1'b1) begin
`ifdef EXTEND_BYTE_HALF_EN
      m_val <= size_sel_i ? extend(half_i, 1'b1, SIG_ExtByte_i)
                          : extend({8'h00, byte_i}, 1'b0, SIG_ExtByte_i);
`else
      m_val <= extend({8'h00, byte_i}, 1'b0, SIG_ExtByte_i);
`endif
      m_vld <= 1'b1;
    end else begin
      m_vld <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("model_value", extendedValue_o, m_val);
      check("model_valid", {31'b0, out_valid_o}, {31'b0, m_vld});
    end
  end

  // Apply inputs at a falling edge, then return at the next falling edge
  // so the registered result is visible.
  task automatic cyc(input logic r, input logic iv, input logic [7:0] b, input logic s);
    reset_i       = r;
    in_valid_i    = iv;
    byte_i        = b;
    SIG_ExtByte_i = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] v, input logic vld);
    check({name, "_val"}, extendedValue_o, v);
    check({name, "_vld"}, {31'b0, out_valid_o}, {31'b0, vld});
  endtask

  initial begin
    half_i     = 16'h0000;
    size_sel_i = 1'b0;

    // Reset with a pending capture: reset wins.
    cyc(1'b1, 1'b1, 8'hFF, 1'b1); lit("reset1", 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 8'hFF, 1'b1); lit("reset2", 32'h0, 1'b0);

    // Sign and zero extension, boundary bytes.
    cyc(1'b0, 1'b1, 8'hFF, 1'b1); lit("sx_ff", 32'hFFFFFFFF, 1'b1);
    cyc(1'b0, 1'b1, 8'h3F, 1'b1); lit("sx_3f", 32'h0000003F, 1'b1);
    cyc(1'b0, 1'b1, 8'hFF, 1'b0); lit("zx_ff", 32'h000000FF, 1'b1);
    cyc(1'b0, 1'b1, 8'h80, 1'b1); lit("sx_80", 32'hFFFFFF80, 1'b1);
    cyc(1'b0, 1'b1, 8'h80, 1'b0); lit("zx_80", 32'h00000080, 1'b1);
    cyc(1'b0, 1'b1, 8'h7F, 1'b1); lit("sx_7f", 32'h0000007F, 1'b1);
    cyc(1'b0, 1'b1, 8'h7F, 1'b0); lit("zx_7f", 32'h0000007F, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1); lit("sx_00", 32'h00000000, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0); lit("zx_00", 32'h00000000, 1'b1);

    // Hold with zero and with unknown idle inputs.
    cyc(1'b0, 1'b1, 8'hA5, 1'b1); lit("sx_a5", 32'hFFFFFFA5, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0); lit("hold1", 32'hFFFFFFA5, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1); lit("hold2", 32'hFFFFFFA5, 1'b0);
    cyc(1'b0, 1'b0, 8'hxx, 1'bx); lit("hold_x", 32'hFFFFFFA5, 1'b0);

    // Reset in the middle of back-to-back captures.
    cyc(1'b0, 1'b1, 8'h01, 1'b1); lit("mid_01", 32'h00000001, 1'b1);
    cyc(1'b1, 1'b1, 8'h82, 1'b1); lit("mid_rst", 32'h00000000, 1'b0);
    cyc(1'b0, 1'b1, 8'h03, 1'b1); lit("mid_03", 32'h00000003, 1'b1);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 40; i++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

`ifdef EXTEND_BYTE_HALF_EN
    size_sel_i = 1'b1;
    half_i     = 16'h8001;
    cyc(1'b0, 1'b1, 8'h00, 1'b1); lit("hx_8001", 32'hFFFF8001, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0); lit("hz_8001", 32'h00008001, 1'b1);
    size_sel_i = 1'b0;
    cyc(1'b0, 1'b1, 8'h80, 1'b1); lit("hb_80", 32'hFFFFFF80, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/extend_byte.md
Name: extend_byte

Overview:
- Registered byte-to-word extender in the load/immediate datapath of the pipelined processor.
- Takes an 8-bit byte and a select bit, and produces a 32-bit value that is either sign-extended or zero-extended.
- Output is registered with one cycle of latency and carries a valid flag, so it can sit at a pipeline-stage boundary.

Parameters:
- OUT_W, 32, width of extendedValue; legal values ≥ 16.
- IN_W, 8, width of byte; fixed at 8, exposed for documentation and must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- byte  input  8  source byte.
- SIG_ExtByte  input  1  1 = sign-extend, 0 = zero-extend.
- in_valid  input  1  sample byte/SIG_ExtByte this cycle.
- extendedValue  output  OUT_W  registered extended result.
- out_valid  output  1  extendedValue holds a result captured on the previous edge.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state changes occur on the rising edge of clk.
- Reset (reset=1 at an edge):
  - extendedValue <= 0 and out_valid <= 0.
  - Reset has priority over in_valid in the same cycle.
  - Any in-flight capture is discarded.
- Capture (reset=0, in_valid=1 at an edge):
  - SIG_ExtByte=1: extendedValue <= {{(OUT_W-8){byte[7]}}, byte}.
  - SIG_ExtByte=0: extendedValue <= {{(OUT_W-8){1'b0}}, byte}.
  - out_valid <= 1.
- Hold (reset=0, in_valid=0):
  - extendedValue keeps its previous value.
  - out_valid <= 0.
- Latency and throughput:
  - Exactly one cycle from input sample to extendedValue/out_valid.
  - Accepts a new input every cycle, with no backpressure.
  - Back-to-back captures each produce a one-cycle-delayed result in order.
- Boundaries:
  - byte=8'h80 with sign mode gives 32'hFFFFFF80.
  - byte=8'h7F gives 32'h0000007F in either mode.
  - byte=8'h00 gives 0 in either mode.
- SIG_ExtByte and byte are sampled only when in_valid=1. X on these inputs while in_valid=0 must not propagate to the outputs.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: EXTEND_BYTE_HALF_EN.
- When defined:
  - Adds input half[15:0] and input size_sel (0 = byte, 1 = halfword).
  - With size_sel=1, the halfword is extended instead of the byte, using the same SIG_ExtByte rule and half[15] as the sign bit.
  - With size_sel=0, behaviour is identical to the base block.
  - size_sel is sampled only with in_valid.
- When undefined:
  - The half and size_sel ports do not exist.
  - Only byte extension is implemented.
  - Reset, latency and valid behaviour are unchanged in both builds.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, byte=8'hFF → extendedValue=32'h0, out_valid=0 throughout.
- Sign extension: byte=8'hFF, SIG_ExtByte=1, in_valid=1 → next edge extendedValue=32'hFFFFFFFF, out_valid=1. Then byte=8'h3F → 32'h0000003F.
- Zero extension: byte=8'hFF, SIG_ExtByte=0 → 32'h000000FF. Byte=8'h80 with SIG_ExtByte=1 → 32'hFFFFFF80; with SIG_ExtByte=0 → 32'h00000080.
- Hold: capture 8'hA5 in sign mode (32'hFFFFFFA5), then in_valid=0 for 3 cycles with byte=8'h00 → value held at 32'hFFFFFFA5, out_valid=0.
- Reset mid-stream: captures every cycle (8'h01, 8'h82, 8'h03), assert reset on the second → extendedValue=0 the cycle after, out_valid=0, next capture resumes normally.
- EXTEND_BYTE_HALF_EN: size_sel=1, half=16'h8001, SIG_ExtByte=1 → 32'hFFFF8001; SIG_ExtByte=0 → 32'h00008001.
